// File: rtl/game_link_pkg.sv
// Shared constants for the two-board link controller.
//   - Protocol bytes exchanged over the UART between the two players.
//   - Controller state encoding (plain constants so older tools can read them).
//   - Helper that builds the score byte sent at game end.
package game_link_pkg;

  // Protocol bytes. SCORE bytes carry the flag in bit 7; START and ACK
  // both have bit 7 clear, so the three kinds never alias.
  localparam logic [7:0] START      = 8'h53;
  localparam logic [7:0] ACK        = 8'h41;
  localparam logic [7:0] SCORE_FLAG = 8'h80;

  typedef logic [2:0] link_state_t;

  localparam link_state_t ST_IDLE       = 3'd0;
  localparam link_state_t ST_WAIT_ACK   = 3'd1;
  localparam link_state_t ST_GAME       = 3'd2;
  localparam link_state_t ST_WAIT_SCORE = 3'd3;
  localparam link_state_t ST_DONE       = 3'd4;

  function automatic logic [7:0] score_byte(input logic [6:0] score);
    return SCORE_FLAG | {1'b0, score};
  endfunction

endpackage

// File: rtl/game_link_ctl.sv
// Two-board link controller. Runs the START/ACK handshake that launches a
// game on both boards, then swaps final scores over the UART.
// Ports:
//   pclk, rst_n          pixel clock; asynchronous active-low reset
//   rect_clicked_play    local PLAY click (1-cycle pulse)
//   game_over, my_score  local game end pulse and the score to send
//   rx_data, rx_valid    received byte and its strobe from the UART RX
//   tx_busy              UART TX occupied
//   tx_data, tx_start    byte and 1-cycle send request to the UART TX
//   uart_start           1-cycle pulse: both boards agreed, game begins
//   op_score(_valid)     peer score and its valid flag
//   link_error           sticky: peer silent or START retries exhausted
module game_link_ctl
  import game_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 7_500_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       rect_clicked_play,
  input  logic       game_over,
  input  logic [6:0] my_score,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       uart_start,
  output logic [6:0] op_score,
  output logic       op_score_valid,
  output logic       link_error
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  link_state_t     state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_byte_q, pend_byte_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            uart_start_q, uart_start_d;
  logic [6:0]      op_score_q, op_score_d;
  logic            op_valid_q, op_valid_d;
  logic            link_error_q, link_error_d;

  logic            rx_is_start, rx_is_ack, rx_is_score;
  logic            in_wait, timeout;
  logic            queue, restart, issue;
  logic [7:0]      queue_byte;

  assign rx_is_start = rx_valid && (rx_data == START);
  assign rx_is_ack   = rx_valid && (rx_data == ACK);
  assign rx_is_score = rx_valid && rx_data[7];
  assign in_wait     = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_SCORE);
  assign timeout     = in_wait && (timer_q == T_LAST);

  // Protocol sequencing
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    op_score_d   = op_score_q;
    op_valid_d   = op_valid_q;
    link_error_d = link_error_q;
    uart_start_d = 1'b0;
    queue        = 1'b0;
    queue_byte   = START;
    restart      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A peer START beats a local click in the same cycle: we answer it.
        if (rx_is_start) begin
          queue        = 1'b1;
          queue_byte   = ACK;
          uart_start_d = 1'b1;
          state_d      = ST_GAME;
        end else if (rect_clicked_play) begin
          queue        = 1'b1;
          queue_byte   = START;
          retry_d      = '0;
          link_error_d = 1'b0;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_is_ack) begin
          uart_start_d = 1'b1;
          state_d      = ST_GAME;
        end else if (rx_is_start) begin
          // Both players clicked: acknowledge the peer and start anyway.
          queue        = 1'b1;
          queue_byte   = ACK;
          uart_start_d = 1'b1;
          state_d      = ST_GAME;
        end else if (timeout) begin
          if (retry_q < R_MAX) begin
            queue      = 1'b1;
            queue_byte = START;
            retry_d    = retry_q + 1'b1;
            restart    = 1'b1;
          end else begin
            link_error_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_GAME: begin
        if (rx_is_score) begin
          op_score_d = rx_data[6:0];
          op_valid_d = 1'b1;
        end
        if (game_over) begin
          queue      = 1'b1;
          queue_byte = score_byte(my_score);
          state_d    = (op_valid_q || rx_is_score) ? ST_DONE : ST_WAIT_SCORE;
        end
      end
      ST_WAIT_SCORE: begin
        if (rx_is_score) begin
          op_score_d = rx_data[6:0];
          op_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else if (timeout) begin
          link_error_d = 1'b1;
          op_valid_d   = 1'b0;
          state_d      = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new game starts with no peer score.
    if ((state_d == ST_GAME) && (state_q != ST_GAME)) begin
      op_score_d = '0;
      op_valid_d = 1'b0;
    end
  end

  // Reply timer: cleared on any state change and on each START resend.
  always_comb begin
    if ((state_d != state_q) || restart || !in_wait) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // One-deep TX queue. Skip the cycle right after a request so the UART has
  // time to raise tx_busy before we could send again.
  assign issue = pend_q && !tx_busy && !tx_start_q;

  always_comb begin
    tx_start_d  = issue;
    tx_data_d   = issue ? pend_byte_q : tx_data_q;
    pend_d      = pend_q && !issue;
    pend_byte_d = pend_byte_q;
    if (queue) begin
      pend_d      = 1'b1;
      pend_byte_d = queue_byte;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      pend_q       <= 1'b0;
      pend_byte_q  <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      uart_start_q <= 1'b0;
      op_score_q   <= '0;
      op_valid_q   <= 1'b0;
      link_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      pend_q       <= pend_d;
      pend_byte_q  <= pend_byte_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      uart_start_q <= uart_start_d;
      op_score_q   <= op_score_d;
      op_valid_q   <= op_valid_d;
      link_error_q <= link_error_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign uart_start     = uart_start_q;
  assign op_score       = op_score_q;
  assign op_score_valid = op_valid_q;
  assign link_error     = link_error_q;

endmodule

// File: tb/tb_game_link_ctl.sv
// Bench for game_link_ctl: constant vector table, hand-written corner
// sequences, and random stimulus compared each cycle against a
// transaction-level model of the link protocol.
module tb_game_link_ctl;
  import game_link_pkg::*;

  localparam int unsigned TO = 100;
  localparam int unsigned MR = 3;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       click = 1'b0;
  logic       go = 1'b0;
  logic [6:0] my_score = '0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       uart_start;
  logic [6:0] op_score;
  logic       op_score_valid;
  logic       link_error;

  game_link_ctl #(
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .pclk             (pclk),
    .rst_n            (rst_n),
    .rect_clicked_play(click),
    .game_over        (go),
    .my_score         (my_score),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_busy          (tx_busy),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .uart_start       (uart_start),
    .op_score         (op_score),
    .op_score_valid   (op_score_valid),
    .link_error       (link_error)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int tx_at[$];
  logic [7:0] tx_log[$];
  int us_cnt = 0;

  // Reference model: phase of the game, absolute deadline, resend count.
  typedef enum int {M_IDLE, M_WACK, M_GAME, M_WSCORE, M_DONE} mst_e;
  mst_e       m_st;
  int         m_deadline;
  int         m_tries;
  bit         m_pend;
  logic [7:0] m_pb;
  bit         m_txs;
  logic [7:0] m_txd;
  bit         m_us;
  logic [6:0] m_sc;
  bit         m_v;
  bit         m_err;

  function automatic logic [31:0] pk(input bit ts, input logic [7:0] td, input bit us,
                                     input logic [6:0] sc, input bit v, input bit e);
    return {13'd0, ts, td, us, sc, v, e};
  endfunction

  function automatic logic [31:0] dut_pk();
    return pk(tx_start, tx_data, uart_start, op_score, op_score_valid, link_error);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_deadline = 0; m_tries = 0; m_pend = 0; m_pb = '0;
    m_txs = 0; m_txd = '0; m_us = 0; m_sc = '0; m_v = 0; m_err = 0;
  endtask

  task automatic model_step(input bit c, input bit g, input logic [6:0] s, input bit rv,
                            input logic [7:0] rd, input bit b);
    bit rs, ra, rsc, expired, want, restart, issue, have;
    logic [7:0] wb;
    mst_e nst;
    rs = rv && (rd == 8'h53);
    ra = rv && (rd == 8'h41);
    rsc = rv && rd[7];
    expired = ((m_st == M_WACK) || (m_st == M_WSCORE)) && (cyc == m_deadline);
    want = 0; wb = 8'h00; restart = 0; nst = m_st; have = m_v;
    m_us = 0;
    if (m_st == M_IDLE || m_st == M_DONE) begin
      if (rs) begin want = 1; wb = 8'h41; m_us = 1; nst = M_GAME; end
      else if (c) begin want = 1; wb = 8'h53; m_tries = 0; m_err = 0; nst = M_WACK; end
    end else if (m_st == M_WACK) begin
      if (ra) begin m_us = 1; nst = M_GAME; end
      else if (rs) begin want = 1; wb = 8'h41; m_us = 1; nst = M_GAME; end
      else if (expired) begin
        if (m_tries < int'(MR)) begin want = 1; wb = 8'h53; m_tries++; restart = 1; end
        else begin m_err = 1; nst = M_IDLE; end
      end
    end else if (m_st == M_GAME) begin
      if (rsc) begin m_sc = rd[6:0]; m_v = 1; end
      if (g) begin
        want = 1; wb = 8'h80 + {1'b0, s};
        nst = (have || rsc) ? M_DONE : M_WSCORE;
      end
    end else begin
      if (rsc) begin m_sc = rd[6:0]; m_v = 1; nst = M_DONE; end
      else if (expired) begin m_err = 1; m_v = 0; nst = M_DONE; end
    end
    if (nst == M_GAME && m_st != M_GAME) begin m_sc = '0; m_v = 0; end
    if (nst != m_st || restart) m_deadline = cyc + int'(TO);
    m_st = nst;
    issue = m_pend && !b && !m_txs;
    m_txs = issue;
    if (issue) begin m_txd = m_pb; m_pend = 0; end
    if (want) begin m_pend = 1; m_pb = wb; end
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit c, input bit g, input logic [6:0] s, input bit rv,
                      input logic [7:0] rd, input bit b);
    click = c; go = g; my_score = s; rx_valid = rv; rx_data = rd; tx_busy = b;
    model_step(c, g, s, rv, rd, b);
    @(posedge pclk);
    #1;
    chk("model", dut_pk(), pk(m_txs, m_txd, m_us, m_sc, m_v, m_err));
    if (tx_start) begin tx_at.push_back(cyc); tx_log.push_back(tx_data); end
    if (uart_start) us_cnt++;
    cyc++;
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) step(0, 0, 7'd0, 0, 8'h00, b);
  endtask

  task automatic clear_log();
    tx_at.delete(); tx_log.delete(); us_cnt = 0;
  endtask

  task automatic do_reset();
    click = 0; go = 0; rx_valid = 0; tx_busy = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("reset_outputs", dut_pk(), 32'd0);
    @(posedge pclk);
    #1;
    rst_n = 1;
    clear_log();
  endtask

  typedef struct {
    bit c; bit g; logic [6:0] s; bit rv; logic [7:0] rd; bit b;
    bit e_ts; logic [7:0] e_td; bit e_us; logic [6:0] e_sc; bit e_v; bit e_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] r;
    logic [7:0] rd;

    //         c  g  s      rv rd     b   ts td     us sc     v  err
    tbl[0]  = '{1, 0, 7'd0,  0, 8'h00, 0,  0, 8'h00, 0, 7'd0,  0, 0};
    tbl[1]  = '{0, 0, 7'd0,  0, 8'h00, 0,  1, 8'h53, 0, 7'd0,  0, 0};
    tbl[2]  = '{0, 0, 7'd0,  1, 8'h41, 0,  0, 8'h53, 1, 7'd0,  0, 0};
    tbl[3]  = '{0, 0, 7'd0,  1, 8'h8C, 0,  0, 8'h53, 0, 7'd12, 1, 0};
    tbl[4]  = '{0, 1, 7'd37, 0, 8'h00, 0,  0, 8'h53, 0, 7'd12, 1, 0};
    tbl[5]  = '{0, 0, 7'd0,  0, 8'h00, 0,  1, 8'hA5, 0, 7'd12, 1, 0};
    tbl[6]  = '{0, 0, 7'd0,  0, 8'h00, 0,  0, 8'hA5, 0, 7'd12, 1, 0};
    tbl[7]  = '{1, 0, 7'd0,  1, 8'h53, 0,  0, 8'hA5, 1, 7'd0,  0, 0};
    tbl[8]  = '{0, 0, 7'd0,  0, 8'h00, 1,  0, 8'hA5, 0, 7'd0,  0, 0};
    tbl[9]  = '{0, 0, 7'd0,  0, 8'h00, 0,  1, 8'h41, 0, 7'd0,  0, 0};
    tbl[10] = '{0, 0, 7'd0,  0, 8'h00, 0,  0, 8'h41, 0, 7'd0,  0, 0};

    // Vector table from reset: handshake, score swap, restart from DONE.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].c, tbl[i].g, tbl[i].s, tbl[i].rv, tbl[i].rd, tbl[i].b);
      chk($sformatf("vec%0d", i), dut_pk(),
          pk(tbl[i].e_ts, tbl[i].e_td, tbl[i].e_us, tbl[i].e_sc, tbl[i].e_v, tbl[i].e_err));
    end
    chk("vec_state", 32'(dut.state_q), 32'(ST_GAME));

    // Clean start: ACK arrives 60 cycles after the click.
    do_reset();
    step(1, 0, 7'd0, 0, 8'h00, 0);
    idle(59, 0);
    step(0, 0, 7'd0, 1, 8'h41, 0);
    chk("clean_uart_start", 32'(uart_start), 32'd1);
    idle(3, 0);
    chk("clean_uart_pulses", us_cnt, 1);
    chk("clean_tx_count", tx_at.size(), 1);
    if (tx_log.size() > 0) chk("clean_tx_byte", tx_log[0], 8'h53);
    chk("clean_state", 32'(dut.state_q), 32'(ST_GAME));

    // Collision while waiting for ACK.
    do_reset();
    step(1, 0, 7'd0, 0, 8'h00, 0);
    idle(10, 0);
    step(0, 0, 7'd0, 1, 8'h53, 0);
    idle(5, 0);
    chk("coll_tx_count", tx_at.size(), 2);
    if (tx_log.size() > 1) chk("coll_ack_byte", tx_log[1], 8'h41);
    chk("coll_uart_pulses", us_cnt, 1);
    chk("coll_state", 32'(dut.state_q), 32'(ST_GAME));

    // Click and peer START in the same cycle: only ACK goes out.
    do_reset();
    step(1, 0, 7'd0, 1, 8'h53, 0);
    idle(8, 0);
    chk("same_tx_count", tx_at.size(), 1);
    if (tx_log.size() > 0) chk("same_tx_byte", tx_log[0], 8'h41);
    chk("same_uart_pulses", us_cnt, 1);

    // Retry exhaustion: four STARTs 100 cycles apart, error at cycle 400.
    do_reset();
    t0 = cyc;
    step(1, 0, 7'd0, 0, 8'h00, 0);
    idle(399, 0);
    chk("retry_err_early", 32'(link_error), 32'd0);
    idle(1, 0);
    chk("retry_err_set", 32'(link_error), 32'd1);
    chk("retry_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("retry_tx_count", tx_at.size(), 4);
    for (int i = 0; i < tx_at.size() && i < 4; i++) begin
      chk($sformatf("retry_gap%0d", i), tx_at[i] - t0, 1 + 100 * i);
      chk($sformatf("retry_byte%0d", i), tx_log[i], 8'h53);
    end
    step(1, 0, 7'd0, 0, 8'h00, 0);
    chk("retry_err_clear", 32'(link_error), 32'd0);
    chk("retry_rearm", 32'(dut.state_q), 32'(ST_WAIT_ACK));

    // Score exchange through WAIT_SCORE.
    do_reset();
    step(0, 0, 7'd0, 1, 8'h53, 0);
    idle(2, 0);
    step(0, 1, 7'd37, 0, 8'h00, 0);
    chk("score_wait_state", 32'(dut.state_q), 32'(ST_WAIT_SCORE));
    idle(2, 0);
    if (tx_log.size() > 0) chk("score_tx_byte", tx_log[tx_log.size() - 1], 8'hA5);
    step(0, 0, 7'd0, 1, 8'h8C, 0);
    chk("score_op", {op_score_valid, op_score}, {1'b1, 7'd12});
    chk("score_state", 32'(dut.state_q), 32'(ST_DONE));

    // TX backpressure: ACK held back for 50 busy cycles.
    do_reset();
    step(0, 0, 7'd0, 1, 8'h53, 1);
    idle(49, 1);
    chk("bp_no_tx", tx_at.size(), 0);
    step(0, 0, 7'd0, 0, 8'h00, 0);
    chk("bp_tx", {tx_start, tx_data}, {1'b1, 8'h41});
    step(0, 0, 7'd0, 0, 8'h00, 0);
    chk("bp_after", {tx_start, tx_data}, {1'b0, 8'h41});

    // Async reset in WAIT_SCORE with a SCORE byte still pending.
    do_reset();
    step(0, 0, 7'd0, 1, 8'h53, 0);
    idle(3, 0);
    step(0, 1, 7'd5, 0, 8'h00, 1);
    chk("rst_pre_state", 32'(dut.state_q), 32'(ST_WAIT_SCORE));
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_async_outputs", dut_pk(), 32'd0);
    @(posedge pclk);
    #1;
    rst_n = 1;
    clear_log();
    idle(10, 0);
    chk("rst_no_tx", tx_at.size(), 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: rd = 8'h53;
        1: rd = 8'h41;
        2: rd = {1'b1, r[6:0]};
        default: rd = r[15:8];
      endcase
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, r[22:16],
           $urandom_range(0, 99) < 8, rd, $urandom_range(0, 99) < 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
